// File: rtl/mul_sched_pkg.sv
// Shared definitions for the sequential 8x8 multiplier scheduler.
//
// Contents:
//   state_e     - scheduler FSM states (IDLE, MUL, DONE)
//   STEP_LAST   - index of the last partial-product step
//   STEP_SHIFT  - left-shift applied to each step's 4x4 partial product
//   shift_pp()  - zero-extends a partial product to 16 bits and shifts it
package mul_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] STEP_LAST = 2'd3;

  // Steps run aL*bL, aL*bH, aH*bL, aH*bH; the cross terms share weight 2^4.
  localparam logic [3:0] STEP_SHIFT [4] = '{4'd0, 4'd4, 4'd4, 4'd8};

  // Zero-extend first so the shift cannot lose high bits of the product.
  function automatic logic [15:0] shift_pp(input logic [7:0] pp,
                                           input logic [1:0] step);
    return {8'b0, pp} << STEP_SHIFT[step];
  endfunction

endpackage

// File: rtl/mul8_seq_sched_core.sv
// 4x4 unsigned combinational multiplier core.
//
// Ports:
//   x  in  4  multiplicand nibble
//   y  in  4  multiplier nibble
//   o  out 8  unsigned product x*y
module mul8_seq_sched_core (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] o
);

  // The 8-bit result context keeps the full product width.
  assign o = x * y;

endmodule

// File: rtl/mul8_seq_sched.sv
// Round-robin scheduler that shares one 4x4 multiplier core among NREQ
// requesters. Each accepted request is an 8x8 unsigned multiply computed as
// four 4x4 partial products over four cycles, accumulated into a 16-bit sum
// and returned on a valid/ready response channel tagged with the requester.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   req_valid  in   NREQ     request pending, one bit per requester
//   req_ready  out  NREQ     one-hot grant (IDLE only)
//   req_a      in   NREQ*8   multiplicands, requester i at [8i+7:8i]
//   req_b      in   NREQ*8   multipliers, same packing
//   rsp_valid  out  1        result available (DONE)
//   rsp_ready  in   1        consumer accepts the result
//   rsp_prod   out  16       unsigned product a*b
//   rsp_id     out  IDW      requester index that issued the request
//   busy       out  1        high whenever the FSM is not IDLE
module mul8_seq_sched
  import mul_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_prod,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  // First set bit of valid, scanning upward from ptr and wrapping.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  ptr);
    logic [IDW-1:0] pick;
    logic           found;
    int             idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && valid[idx]) begin
        found = 1'b1;
        pick  = idx[IDW-1:0];
      end
    end
    return pick;
  endfunction

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]      step_q, step_d;
  logic [15:0]     acc_q, acc_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [15:0]     prod_q, prod_d;

  logic [7:0]      a_arr [NREQ];
  logic [7:0]      b_arr [NREQ];
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  grant_next;
  logic            any_valid;
  logic [3:0]      core_x;
  logic [3:0]      core_y;
  logic [7:0]      core_o;
  logic [15:0]     acc_sum;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[8*gi +: 8];
    assign b_arr[gi] = req_b[8*gi +: 8];
  end

  assign any_valid  = |req_valid;
  assign grant_idx  = rr_pick(req_valid, rr_ptr_q);
  assign grant_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  // step[1] picks the a nibble and step[0] the b nibble, giving the
  // aL*bL, aL*bH, aH*bL, aH*bH order.
  assign core_x = step_q[1] ? a_q[7:4] : a_q[3:0];
  assign core_y = step_q[0] ? b_q[7:4] : b_q[3:0];

  mul8_seq_sched_core u_core (
    .x (core_x),
    .y (core_y),
    .o (core_o)
  );

  assign acc_sum = acc_q + shift_pp(core_o, step_q);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    step_d    = step_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    prod_d    = prod_q;
    req_ready = '0;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          req_ready[grant_idx] = 1'b1;
          a_d      = a_arr[grant_idx];
          b_d      = b_arr[grant_idx];
          id_d     = grant_idx;
          rr_ptr_d = grant_next;
          acc_d    = '0;
          step_d   = '0;
          state_d  = MUL;
        end
      end
      MUL: begin
        acc_d  = acc_sum;
        step_d = step_q + 2'd1;
        if (step_q == STEP_LAST) begin
          prod_d  = acc_sum;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      step_q   <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      prod_q   <= prod_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_prod  = prod_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_mul8_seq_sched.sv
// Testbench for mul8_seq_sched. A cycle-level reference model grants
// requests round-robin, pushes the expected product/id on every accept,
// and a separate monitor compares each presented response against the
// queue head.
module tb_mul8_seq_sched;

  localparam int NREQ = 2;
  localparam int IDW  = $clog2(NREQ);

  typedef struct {
    int id;
    int prod;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_prod;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  int   total = 0;
  int   bad   = 0;
  int   n_acc = 0;
  exp_t exp_q [$];

  // Reference model: 0 idle, 1 computing, 2 result presented.
  int   m_state = 0;
  int   m_rem   = 0;
  int   m_rr    = 0;
  bit   pending [NREQ];
  int   pa [NREQ];
  int   pb [NREQ];
  int   wait_cnt [NREQ];

  mul8_seq_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_prod  (rsp_prod),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  function automatic int modelGrant();
    if (m_state != 0) return -1;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (m_rr + i) % NREQ;
      if (pending[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit anyPending();
    for (int i = 0; i < NREQ; i++) if (pending[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic newReq(input int i, input int a, input int b);
    pending[i]  = 1'b1;
    pa[i]       = a;
    pb[i]       = b;
    wait_cnt[i] = 0;
  endtask

  // One clock of stimulus: drive at negedge, check grant/status, then
  // advance the model past the rising edge.
  task automatic applyStimulus(input bit rdy);
    int              g;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]     = pending[i];
      req_a[8*i +: 8]  = pa[i][7:0];
      req_b[8*i +: 8]  = pb[i][7:0];
    end
    rsp_ready = rdy;
    #1;
    g = modelGrant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    checkOutput("req_ready", int'(req_ready), int'(exp_rdy));
    checkOutput("busy", int'(busy), (m_state != 0) ? 1 : 0);
    checkOutput("rsp_valid", int'(rsp_valid), (m_state == 2) ? 1 : 0);
    @(posedge clk);
    if (g >= 0) begin
      exp_q.push_back('{id: g, prod: pa[g] * pb[g]});
      checkOutput("wait_bound", (wait_cnt[g] <= NREQ) ? 1 : 0, 1);
      for (int j = 0; j < NREQ; j++) if (j != g && pending[j]) wait_cnt[j]++;
      wait_cnt[g] = 0;
      pending[g]  = 1'b0;
      m_rr        = (g + 1) % NREQ;
      m_state     = 1;
      m_rem       = 4;
      n_acc++;
    end else if (m_state == 1) begin
      m_rem--;
      if (m_rem == 0) m_state = 2;
    end else if (m_state == 2 && rdy) begin
      m_state = 0;
    end
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (m_state == 0 && !anyPending() && exp_q.size() == 0) break;
      applyStimulus(1'b1);
    end
    checkOutput("drain_queue", exp_q.size(), 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, int'(req_ready), 0);
    checkOutput({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_rsp_prod"}, int'(rsp_prod), 0);
    checkOutput({tag, "_rsp_id"}, int'(rsp_id), 0);
  endtask

  // Monitor: while a result is presented it must match the oldest
  // expectation every cycle; it is retired on the handshake.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_rsp", int'(rsp_valid), 0);
      end else begin
        checkOutput("rsp_prod", int'(rsp_prod), exp_q[0].prod);
        checkOutput("rsp_id", int'(rsp_id), exp_q[0].id);
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int base;
    int cyc;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single request");
    newReq(0, 'hFF, 'hFF);
    drain(30);

    $display("[TB] simultaneous requests");
    newReq(0, 3, 5);
    newReq(1, 'h10, 'h10);
    drain(40);
    newReq(1, 7, 9);
    newReq(0, 2, 2);
    drain(40);

    $display("[TB] backpressure");
    newReq(1, 'h12, 'h34);
    applyStimulus(1'b0);
    newReq(0, 'h55, 'h66);
    repeat (15) applyStimulus(1'b0);
    drain(40);

    $display("[TB] zero operand");
    newReq(0, 'h00, 'hAB);
    drain(30);
    newReq(0, 'h80, 'h02);
    drain(30);

    $display("[TB] reset mid-operation");
    newReq(0, 'h0F, 'h0F);
    for (int c = 0; c < 10 && m_state != 1; c++) applyStimulus(1'b1);
    checkOutput("reset_test_accepted", m_state, 1);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      pending[i]  = 1'b0;
      wait_cnt[i] = 0;
    end
    #1;
    checkResetOutputs("midreset");
    exp_q.delete();
    m_state = 0;
    m_rem   = 0;
    m_rr    = 0;
    @(negedge clk);
    rst_n = 1'b1;
    newReq(0, 1, 1);
    newReq(1, 2, 2);
    drain(40);

    $display("[TB] random sweep");
    base = n_acc;
    cyc  = 0;
    while ((n_acc - base) < 2000 && cyc < 40000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pending[i] && $urandom_range(0, 99) < 40)
          newReq(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end
      applyStimulus($urandom_range(0, 99) < 70);
      cyc++;
    end
    checkOutput("sweep_count", n_acc - base, 2000);
    for (int i = 0; i < NREQ; i++) pending[i] = 1'b0;
    drain(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
